// File: rtl/i2c_pkg.sv
`default_nettype none
//============================================================================
// Module : i2c_pkg
// Brief  : Shared state encoding and constants for the I2C slave receiver.
// Rev    : 1.0  initial release
//============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_t;

  localparam logic [6:0] c_default_slave_addr = 7'h50;
  localparam logic [3:0] c_bits_per_byte      = 4'd8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_slave_rx_if.sv
`default_nettype none
//============================================================================
// Module : i2c_slave_rx_if
// Brief  : Bus pins and receive-side handshake of the I2C slave receiver.
// Rev    : 1.0  initial release
//============================================================================
interface i2c_slave_rx_if;
  logic       scl;
  logic       sda;
  logic       ack_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       addr_match;
  logic [7:0] byte_cnt;
  logic       overrun;

  modport slave (
    input  scl, sda, rx_ready,
    output ack_n, rx_data, rx_valid, busy, addr_match, byte_cnt, overrun
  );

  modport master (
    output scl, sda, rx_ready,
    input  ack_n, rx_data, rx_valid, busy, addr_match, byte_cnt, overrun
  );
endinterface
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
//============================================================================
// Module : i2c_bus_sync
// Brief  : scl/sda synchronizer plus history flop; emits edge/START/STOP events.
// Rev    : 1.0  initial release
//============================================================================
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic scl,
  input  wire logic sda,
  output logic      sda_s,
  output logic      scl_rise,
  output logic      scl_fall,
  output logic      start_det,
  output logic      stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_hist;
  logic                   r_sda_hist;
  logic                   w_scl;
  logic                   w_sda;

  // Reset to the idle-bus level so the first cycles out of reset see no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync[0] <= scl;
      r_sda_sync[0] <= sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_scl_sync[i] <= r_scl_sync[i-1];
        r_sda_sync[i] <= r_sda_sync[i-1];
      end
      r_scl_hist <= w_scl;
      r_sda_hist <= w_sda;
    end
  end

  assign w_scl     = r_scl_sync[SYNC_STAGES-1];
  assign w_sda     = r_sda_sync[SYNC_STAGES-1];
  assign sda_s     = w_sda;
  assign scl_rise  =  w_scl & ~r_scl_hist;
  assign scl_fall  = ~w_scl &  r_scl_hist;
  assign start_det =  w_scl & r_sda_hist & ~w_sda;
  assign stop_det  =  w_scl & ~r_sda_hist & w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_rx.sv
`default_nettype none
//============================================================================
// Module : i2c_slave_rx
// Brief  : Write-only I2C slave receiver with a valid/ready byte output.
// Rev    : 1.0  initial release
//============================================================================
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = c_default_slave_addr,
  parameter int         SYNC_STAGES = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  i2c_slave_rx_if.slave bus
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (bus.scl),
    .sda       (bus.sda),
    .sda_s     (w_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  state_t     r_state,      w_state_nxt;
  logic [3:0] r_bit_cnt,    w_bit_cnt_nxt;
  logic [7:0] r_shreg,      w_shreg_nxt;
  logic [7:0] r_rx_data,    w_rx_data_nxt;
  logic       r_rx_valid,   w_rx_valid_nxt;
  logic [7:0] r_byte_cnt,   w_byte_cnt_nxt;
  logic       r_addr_match, w_addr_match_nxt;
  logic       r_overrun,    w_overrun_nxt;
  logic       r_accepted,   w_accepted_nxt;
  logic       w_can_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 4'd0;
      r_shreg      <= 8'd0;
      r_rx_data    <= 8'd0;
      r_rx_valid   <= 1'b0;
      r_byte_cnt   <= 8'd0;
      r_addr_match <= 1'b0;
      r_overrun    <= 1'b0;
      r_accepted   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_addr_match <= w_addr_match_nxt;
      r_overrun    <= w_overrun_nxt;
      r_accepted   <= w_accepted_nxt;
    end
  end

  assign w_can_accept = !r_rx_valid || bus.rx_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shreg_nxt      = r_shreg;
    w_rx_data_nxt    = r_rx_data;
    w_rx_valid_nxt   = r_rx_valid;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_addr_match_nxt = r_addr_match;
    w_overrun_nxt    = 1'b0;
    w_accepted_nxt   = r_accepted;

    if (r_rx_valid && bus.rx_ready)
      w_rx_valid_nxt = 1'b0;

    if (w_stop) begin
      w_state_nxt      = ST_IDLE;
      w_bit_cnt_nxt    = 4'd0;
      w_addr_match_nxt = 1'b0;
    end else if (w_start) begin
      // Repeated START restarts addressing but keeps any pending rx byte.
      w_state_nxt      = ST_ADDR;
      w_bit_cnt_nxt    = 4'd0;
      w_byte_cnt_nxt   = 8'd0;
      w_addr_match_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_DATA: begin
          if (w_scl_rise && r_bit_cnt < c_bits_per_byte) begin
            w_shreg_nxt   = {r_shreg[6:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && r_bit_cnt == c_bits_per_byte) begin
            if (r_state == ST_ADDR) begin
              if (r_shreg == {SLAVE_ADDR, 1'b0}) begin
                w_state_nxt      = ST_ADDR_ACK;
                w_addr_match_nxt = 1'b1;
              end else begin
                w_state_nxt = ST_IGNORE;
              end
            end else begin
              w_state_nxt = ST_DATA_ACK;
              if (w_can_accept) begin
                w_rx_data_nxt  = r_shreg;
                w_rx_valid_nxt = 1'b1;
                w_byte_cnt_nxt = sat_inc8(r_byte_cnt);
                w_accepted_nxt = 1'b1;
              end else begin
                w_overrun_nxt  = 1'b1;
                w_accepted_nxt = 1'b0;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = 4'd0;
          end
        end
        ST_IGNORE: w_addr_match_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.ack_n      = !((r_state == ST_ADDR_ACK) ||
                            (r_state == ST_DATA_ACK && r_accepted));
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.addr_match = r_addr_match;
  assign bus.byte_cnt   = r_byte_cnt;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`default_nettype none
//============================================================================
// Module : tb_i2c_slave_rx
// Brief  : Self-checking bench: bit-level I2C master against a transaction model.
// Rev    : 1.0  initial release
//============================================================================
module tb_i2c_slave_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_slave_rx_if bus ();

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Expected steady-state outputs, maintained by the transaction model.
  bit       chk_en = 1'b0;
  logic       e_ack, e_busy, e_match, e_valid;
  logic [7:0] e_data, e_bcnt;
  bit         m_match;
  int         x_ovr = 0, x_hs = 0;
  int         n_ovr = 0, n_hs = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("ack_n",      int'(bus.ack_n),      int'(e_ack));
      chk("busy",       int'(bus.busy),       int'(e_busy));
      chk("addr_match", int'(bus.addr_match), int'(e_match));
      chk("rx_valid",   int'(bus.rx_valid),   int'(e_valid));
      chk("rx_data",    int'(bus.rx_data),    int'(e_data));
      chk("byte_cnt",   int'(bus.byte_cnt),   int'(e_bcnt));
      chk("overrun",    int'(bus.overrun),    0);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.overrun) n_ovr++;
      if (bus.rx_valid && bus.rx_ready) n_hs++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One bus phase: let the synchronizer settle, then check a stable window.
  task automatic phase();
    repeat (5) @(negedge clk);
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    chk_en = 1'b0;
  endtask

  task automatic model_reset();
    e_ack = 1'b1; e_busy = 1'b0; e_match = 1'b0; e_valid = 1'b0;
    e_data = 8'h00; e_bcnt = 8'h00; m_match = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    bus.rx_ready = v;
    if (v && e_valid) begin
      x_hs++;
      e_valid = 1'b0;
    end
    phase();
  endtask

  task automatic start_cond();
    if (bus.scl == 1'b0) begin
      bus.sda = 1'b1; phase();
      bus.scl = 1'b1; phase();
    end
    bus.sda = 1'b0;
    e_busy = 1'b1; e_bcnt = 8'h00; e_match = 1'b0; e_ack = 1'b1; m_match = 1'b0;
    phase();
    bus.scl = 1'b0; phase();
  endtask

  task automatic stop_cond();
    bus.sda = 1'b0; phase();
    bus.scl = 1'b1; phase();
    bus.sda = 1'b1;
    e_busy = 1'b0; e_match = 1'b0; e_ack = 1'b1;
    phase();
  endtask

  // Outcome of a completed byte, decided from the protocol rules.
  task automatic model_byte(input logic [7:0] b, input bit is_addr);
    if (is_addr) begin
      m_match = (b == {7'h50, 1'b0});
      e_match = m_match;
      e_ack   = !m_match;
    end else if (m_match) begin
      if (!e_valid || bus.rx_ready) begin
        e_data  = b;
        e_valid = !bus.rx_ready;
        e_bcnt  = (e_bcnt == 8'hFF) ? 8'hFF : e_bcnt + 8'd1;
        e_ack   = 1'b0;
        if (bus.rx_ready) x_hs++;
      end else begin
        x_ovr++;
        e_ack = 1'b1;
      end
    end else begin
      e_ack = 1'b1;
    end
  endtask

  task automatic send_bit(input logic b);
    bus.sda = b;    phase();
    bus.scl = 1'b1; phase();
    bus.scl = 1'b0; phase();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_addr);
    for (int i = 7; i >= 0; i--) begin
      bus.sda = b[i]; phase();
      bus.scl = 1'b1; phase();
      bus.scl = 1'b0;
      if (i == 0) model_byte(b, is_addr);
      phase();
    end
    bus.sda = 1'b1; phase();
    bus.scl = 1'b1; phase();
    bus.scl = 1'b0;
    e_ack = 1'b1;
    phase();
  endtask

  task automatic check_counts(input string tag);
    chk({tag, ".overrun_pulses"}, n_ovr, x_ovr);
    chk({tag, ".rx_handshakes"},  n_hs,  x_hs);
  endtask

  initial begin
    int n_before;
    rst = 1'b1;
    bus.scl = 1'b1; bus.sda = 1'b1; bus.rx_ready = 1'b0;
    model_reset();
    phase();
    rst = 1'b0;
    phase();
    chk("reset.ack_n", int'(bus.ack_n), 1);
    chk("reset.busy",  int'(bus.busy),  0);

    // Basic write, consumer always ready.
    set_ready(1'b1);
    n_before = n_hs;
    start_cond();
    send_byte(8'hA0, 1'b1);
    send_byte(8'hA5, 1'b0);
    stop_cond();
    chk("basic.rx_data",  int'(bus.rx_data),  8'hA5);
    chk("basic.byte_cnt", int'(bus.byte_cnt), 1);
    chk("basic.busy",     int'(bus.busy),     0);
    chk("basic.pulse",    n_hs - n_before,    1);
    check_counts("basic");

    // Wrong address, then read to the right address: both ignored.
    start_cond();
    send_byte(8'hA2, 1'b1);
    send_byte(8'h77, 1'b0);
    chk("wrong_addr.match", int'(bus.addr_match), 0);
    stop_cond();
    start_cond();
    send_byte(8'hA1, 1'b1);
    send_byte(8'h66, 1'b0);
    stop_cond();
    chk("ignored.rx_data", int'(bus.rx_data), 8'hA5);
    check_counts("ignored");

    // Consumer stalled: second byte overruns.
    set_ready(1'b0);
    n_before = n_ovr;
    start_cond();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    stop_cond();
    chk("overrun.rx_data",  int'(bus.rx_data),  8'h11);
    chk("overrun.rx_valid", int'(bus.rx_valid), 1);
    chk("overrun.pulses",   n_ovr - n_before,   1);
    set_ready(1'b1);
    check_counts("overrun");

    // Repeated START restarts the byte count.
    start_cond();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h33, 1'b0);
    start_cond();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h44, 1'b0);
    stop_cond();
    chk("rstart.byte_cnt", int'(bus.byte_cnt), 1);
    chk("rstart.rx_data",  int'(bus.rx_data),  8'h44);

    // Reset in the middle of a data byte, then a clean transfer.
    start_cond();
    send_byte(8'hA0, 1'b1);
    for (int i = 7; i >= 4; i--) send_bit(i[0]);
    rst = 1'b1;
    model_reset();
    phase();
    bus.scl = 1'b1; bus.sda = 1'b1;
    phase();
    rst = 1'b0;
    phase();
    chk("midrst.rx_data", int'(bus.rx_data), 0);
    start_cond();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h5A, 1'b0);
    stop_cond();
    chk("after_rst.rx_data",  int'(bus.rx_data),  8'h5A);
    chk("after_rst.byte_cnt", int'(bus.byte_cnt), 1);
    check_counts("after_rst");

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      int sel, nb;
      logic [7:0] a;
      set_ready(logic'($urandom_range(0, 1)));
      start_cond();
      sel = $urandom_range(0, 3);
      a = (sel < 2) ? 8'hA0 : (sel == 2) ? 8'hA1 : 8'($urandom_range(0, 255));
      send_byte(a, 1'b1);
      nb = $urandom_range(0, 3);
      for (int k = 0; k < nb; k++) send_byte(8'($urandom_range(0, 255)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        start_cond();
        send_byte(8'hA0, 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b0);
      end
      stop_cond();
      check_counts("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit bus address this receiver answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on scl/sda.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 scl  input  1  I2C clock from the bus master, asynchronous to clk.
REQ-006 sda  input  1  I2C data from the bus master, asynchronous to clk.
REQ-007 ack_n  output  1  acknowledge to the master's ack input; 0=ACK, 1=NACK/released.
REQ-008 rx_data  output  8  last accepted data byte.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 rx_ready  input  1  consumer accepts the byte in the cycle where rx_valid&rx_ready.
REQ-011 busy  output  1  1 from START detection until STOP detection.
REQ-012 addr_match  output  1  1 while the current transaction is addressed to SLAVE_ADDR with write.
REQ-013 byte_cnt  output  8  count of data bytes accepted since the last START; saturates at 255.
REQ-014 overrun  output  1  one-clk pulse when a completed byte is dropped.

Function
REQ-015 scl/sda SHALL pass a SYNC_STAGES flop synchronizer, then one history flop; edge and condition events are visible SYNC_STAGES+1 clk after the pin change.
REQ-016 START = sda falling while synced scl high; STOP = sda rising while synced scl high; bit sample = scl rising edge; ack timing = scl falling edge.
REQ-017 Event priority SHALL be: STOP > START > scl edges.
REQ-018 States SHALL be: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-019 IDLE: START -> ADDR, bit_cnt=0, byte_cnt=0; all other events are ignored.
REQ-020 ADDR: each scl rise shifts sda into a shift register MSB first, bit_cnt+1; on the first scl fall with bit_cnt==8: {addr[6:0],rw} match with rw=0 -> ADDR_ACK and addr_match=1; otherwise -> IGNORE.
REQ-021 ADDR_ACK: ack_n=0 for the whole state; next scl fall -> DATA, bit_cnt=0.
REQ-022 DATA: shift as in ADDR; on the first scl fall with bit_cnt==8, the byte completes.
REQ-023 At byte completion with rx_valid=0 (or rx_valid&rx_ready in the same cycle): rx_data<=byte, rx_valid<=1, byte_cnt+1 (saturating), -> DATA_ACK.
REQ-024 At byte completion with rx_valid=1 and rx_ready=0: the byte is dropped, overrun pulses, -> DATA_NACK behaviour (ack_n stays 1 for the ack bit), then DATA.
REQ-025 DATA_ACK: ack_n=0 only if the byte was accepted; next scl fall -> DATA, bit_cnt=0.
REQ-026 IGNORE: ack_n=1, addr_match=0; wait for START or STOP.
REQ-027 START in any non-IDLE state (repeated start) SHALL go to ADDR, clear bit_cnt, byte_cnt and addr_match, and leave rx_valid/rx_data untouched.
REQ-028 STOP in any state SHALL go to IDLE: ack_n=1, busy=0, addr_match=0; rx_valid is retained.
REQ-029 rx_valid SHALL clear on rx_valid&rx_ready unless a new byte is accepted in the same cycle.
REQ-030 ack_n SHALL be 1 in every state other than ADDR_ACK and an accepting DATA_ACK.
REQ-031 bit_cnt SHALL be 4 bits, range 0..8, and never wrap.

Reset
REQ-032 rst SHALL force IDLE, ack_n=1, rx_data=0, rx_valid=0, busy=0, addr_match=0, byte_cnt=0, overrun=0, bit_cnt=0.
REQ-033 Synchronizer and history flops SHALL reset to 1 (bus idle) so that no false START/STOP is detected after reset.
REQ-034 Reset mid-transaction SHALL abandon the transfer; the receiver re-engages only at the next START.

Structure
REQ-035 Package i2c_pkg SHALL hold the state encoding, the default SLAVE_ADDR and the bit-count constant 8.
REQ-036 Sub-module i2c_bus_sync SHALL contain the synchronizer and history flop and output scl_rise, scl_fall, start_det and stop_det.

Verification
REQ-037 START, addr 7'h50+W, data 8'hA5, STOP, rx_ready=1 -> ack_n=0 in both ack slots, rx_data=8'hA5, rx_valid pulse, byte_cnt=1, busy falls after STOP.
REQ-038 Address 7'h51+W -> ack_n stays 1, addr_match=0, state IGNORE, no rx_valid.
REQ-039 Address 7'h50+R -> NACK, IGNORE.
REQ-040 rx_ready=0, bytes 8'h11 then 8'h22 -> first byte ACKed, second NACKed, overrun one pulse, rx_data stays 8'h11.
REQ-041 Repeated START after byte 8'h33, then addr 7'h50+W and 8'h44 -> byte_cnt restarts at 1, rx_data=8'h44.
REQ-042 rst asserted at bit 4 of the data byte -> all outputs at reset values; a following full transfer of 8'h5A is received correctly.
